// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, signed or unsigned per transaction
//   clk, rst         : clock, synchronous active-high reset
//   start, is_signed : request and operand signedness, sampled when ready=1
//   a, b             : WIDTH-bit multiplicand and multiplier, captured with start
//   ready, busy, done: can accept start / iterating / one-cycle product-valid pulse
//   product          : 2*WIDTH-bit result, held from done until the next done
module booth_mult_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [WIDTH+1:0]   acc_q, acc_sum, acc_d;
  logic [WIDTH:0]     m_q, q_q, q_d;
  logic               q1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q, product_d;
  // acc is one bit wider than m so that subtracting the most negative m cannot overflow
  always_comb begin
    acc_sum   = (q_q[0] & ~q1_q) ? acc_q - {m_q[WIDTH], m_q} :
                (~q_q[0] & q1_q) ? acc_q + {m_q[WIDTH], m_q} : acc_q;
    acc_d     = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
    q_d       = {acc_sum[0], q_q[WIDTH:1]};
    product_d = {acc_d[WIDTH-2:0], q_d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      q1_q  <= q_q[0];
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_q   <= DONE;
        product_q <= product_d;
      end
    end else if (start) begin
      state_q <= RUN;
      acc_q   <= '0;
      m_q     <= {is_signed & a[WIDTH-1], a};
      q_q     <= {is_signed & b[WIDTH-1], b};
      q1_q    <= 1'b0;
      cnt_q   <= CNT_W'(WIDTH + 1);
    end else begin
      state_q <= IDLE;
    end
  end
  assign ready   = (state_q == IDLE) | (state_q == DONE);
  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign product = product_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and random checks of booth_mult_seq at WIDTH=8 and WIDTH=16
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0, s8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic ready8, busy8, done8;
  logic [15:0] product8;
  logic start16 = 1'b0, s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic ready16, busy16, done16;
  logic [31:0] product16;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(s8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );
  booth_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(s16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .product(product16)
  );
  task automatic wait8(output int cyc, output int nb, output int nr);
    cyc = 1;
    nb = 0;
    nr = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      nb += int'(busy8);
      nr += int'(ready8);
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic mul8(input logic sgn, input logic [7:0] aa, input logic [7:0] bb,
                      output logic [15:0] p, output int cyc, output int nb, output int nr);
    s8 = sgn;
    a8 = aa;
    b8 = bb;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    s8 = ~sgn;
    wait8(cyc, nb, nr);
    p = product8;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready8); end
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
    if (product8 !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product8); end
    if (product16 !== 32'h0 || ready16 !== 1'b1) begin errors++; $display("FAIL reset_w16: got product=%h ready=%b expected 0 1", product16, ready16); end
  endtask
  task automatic test_signed_basic;
    logic [15:0] p;
    int cyc, nb, nr;
    mul8(1'b1, 8'hFD, 8'h05, p, cyc, nb, nr);
    checks += 6;
    if (p !== 16'hFFF1) begin errors++; $display("FAIL m3x5_product: got %h expected fff1", p); end
    if (cyc !== 10) begin errors++; $display("FAIL m3x5_latency: got %0d expected 10", cyc); end
    if (nb !== 9) begin errors++; $display("FAIL m3x5_busy_cycles: got %0d expected 9", nb); end
    if (nr !== 0) begin errors++; $display("FAIL m3x5_ready_in_run: got %0d expected 0", nr); end
    @(negedge clk);
    if (done8 !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done8); end
    if (product8 !== 16'hFFF1) begin errors++; $display("FAIL product_held: got %h expected fff1", product8); end
  endtask
  task automatic test_unsigned;
    logic [15:0] p;
    int cyc, nb, nr;
    mul8(1'b0, 8'hFF, 8'hFF, p, cyc, nb, nr);
    checks++;
    if (p !== 16'hFE01) begin errors++; $display("FAIL ffxff_unsigned: got %h expected fe01", p); end
    mul8(1'b1, 8'hFF, 8'hFF, p, cyc, nb, nr);
    checks++;
    if (p !== 16'h0001) begin errors++; $display("FAIL ffxff_signed: got %h expected 0001", p); end
  endtask
  task automatic test_most_negative;
    logic [15:0] p;
    int cyc, nb, nr;
    mul8(1'b1, 8'h80, 8'h80, p, cyc, nb, nr);
    checks++;
    if (p !== 16'h4000) begin errors++; $display("FAIL 80x80_signed: got %h expected 4000", p); end
    mul8(1'b1, 8'h80, 8'h7F, p, cyc, nb, nr);
    checks++;
    if (p !== 16'hC080) begin errors++; $display("FAIL 80x7f_signed: got %h expected c080", p); end
  endtask
  task automatic test_back_to_back;
    logic [7:0]  va [3] = '{8'h03, 8'hC8, 8'h7F};
    logic [7:0]  vb [3] = '{8'hFB, 8'h02, 8'h7F};
    logic        vs [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ve [3] = '{16'hFFF1, 16'h0190, 16'h3F01};
    int cyc;
    @(negedge clk);
    s8 = vs[0];
    a8 = va[0];
    b8 = vb[0];
    start8 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 40) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        s8 = 1'($urandom);
        @(negedge clk);
        cyc++;
      end
      checks += 2;
      if (cyc !== 10) begin errors++; $display("FAIL b2b_interval_%0d: got %0d expected 10", k, cyc); end
      if (product8 !== ve[k]) begin errors++; $display("FAIL b2b_product_%0d: got %h expected %h", k, product8, ve[k]); end
      if (k < 2) begin
        s8 = vs[k+1];
        a8 = va[k+1];
        b8 = vb[k+1];
      end else start8 = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid_run;
    logic [15:0] p;
    int cyc, nb, nr, seen;
    s8 = 1'b0;
    a8 = 8'h12;
    b8 = 8'h34;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (ready8 !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready8); end
    if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
    if (done8 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done8); end
    if (product8 !== 16'h0000) begin errors++; $display("FAIL midrst_product: got %h expected 0000", product8); end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen += int'(done8);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen); end
    mul8(1'b0, 8'd6, 8'd7, p, cyc, nb, nr);
    checks++;
    if (p !== 16'h002A || cyc !== 10) begin errors++; $display("FAIL after_rst_6x7: got %h in %0d expected 002a in 10", p, cyc); end
  endtask
  task automatic test_width16;
    int cyc;
    s16 = 1'b1;
    a16 = 16'h8000;
    b16 = 16'h7FFF;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 1;
    while (done16 !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checks += 2;
    if (product16 !== 32'hC0008000) begin errors++; $display("FAIL w16_product: got %h expected c0008000", product16); end
    if (cyc !== 18) begin errors++; $display("FAIL w16_latency: got %0d expected 18", cyc); end
  endtask
  task automatic test_random;
    logic [15:0] p, exp;
    logic [7:0] aa, bb;
    logic sg;
    logic signed [17:0] full;
    int cyc, nb, nr;
    for (int i = 0; i < 1000; i++) begin
      aa = 8'($urandom);
      bb = 8'($urandom);
      sg = 1'($urandom);
      full = $signed({sg & aa[7], aa}) * $signed({sg & bb[7], bb});
      exp = full[15:0];
      mul8(sg, aa, bb, p, cyc, nb, nr);
      checks++;
      if (p !== exp || cyc !== 10) begin
        errors++;
        $display("FAIL rand_%0d s=%b %h*%h: got %h in %0d expected %h in 10", i, sg, aa, bb, p, cyc, exp);
      end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_signed_basic;
    test_unsigned;
    test_most_negative;
    test_back_to_back;
    test_reset_mid_run;
    test_width16;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
